// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the fetch/decode stage register and the
// instruction-queue storage entry.
package rv32i_types;

  localparam int IQ_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
    logic        valid;
  } if_id_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] order;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular fetch-to-decode instruction FIFO.
// Each enqueued packet is stamped with a 64-bit retire order.
module inst_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_valid,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  output logic             enq_ready,
  input  logic             deq_ready,
  output if_id_stage_reg_t deq_data,
  output logic             deq_valid,
  input  logic             flush,
  input  logic [63:0]      flush_order,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Pointer MSB is the wrap bit; low bits index storage.
  logic [PTR_W:0] head_ptr;
  logic [PTR_W:0] tail_ptr;
  logic [63:0]    order_ctr;
  iq_entry_t      mem [DEPTH];

  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;

  assign empty    = (head_ptr == tail_ptr);
  assign full     = (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]) &&
                    (head_ptr[PTR_W] != tail_ptr[PTR_W]);
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign enq_fire  = enq_valid & ~full & ~flush;
  assign deq_fire  = ~empty & deq_ready & ~flush;
  assign count     = tail_ptr - head_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      order_ctr <= '0;
    end else if (flush) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      order_ctr <= flush_order;
    end else begin
      if (enq_fire) begin
        tail_ptr  <= tail_ptr + PTR_ONE;
        order_ctr <= order_ctr + 64'd1;
      end
      if (deq_fire) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
    end
  end

  // Storage is deliberately left unreset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail_ptr[PTR_W-1:0]] <= '{inst: enq_inst, pc: enq_pc, order: order_ctr};
    end
  end

  always_comb begin
    deq_data = '0;
    if (!empty) begin
      deq_data.inst  = mem[head_ptr[PTR_W-1:0]].inst;
      deq_data.pc    = mem[head_ptr[PTR_W-1:0]].pc;
      deq_data.order = mem[head_ptr[PTR_W-1:0]].order;
      deq_data.valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a queue-based reference scoreboard.
module tb_inst_queue;
  import rv32i_types::*;

  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enq_valid;
  logic [31:0]      enq_inst;
  logic [31:0]      enq_pc;
  logic             enq_ready;
  logic             deq_ready;
  if_id_stage_reg_t deq_data;
  logic             deq_valid;
  logic             flush;
  logic [63:0]      flush_order;
  logic [4:0]       count;

  iq_entry_t   sb[$];
  logic [63:0] m_ord;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc), .enq_ready(enq_ready),
    .deq_ready(deq_ready), .deq_data(deq_data), .deq_valid(deq_valid),
    .flush(flush), .flush_order(flush_order), .count(count)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic dr,
                       input logic fl = 1'b0, input logic [63:0] fo = 64'd0);
    enq_valid   = ev;
    enq_inst    = pc ^ 32'h00500093;
    enq_pc      = pc;
    deq_ready   = dr;
    flush       = fl;
    flush_order = fo;
  endtask

  // Compare visible state against the scoreboard, advance the model, then clock.
  task automatic tick();
    iq_entry_t e;
    int n;
    n = sb.size();
    chk("deq_valid", 192'(deq_valid), 192'(n != 0));
    chk("enq_ready", 192'(enq_ready), 192'(n < DEPTH));
    chk("count", 192'(count), 192'(n));
    chk("data_valid", 192'(deq_data.valid), 192'(n != 0));
    if (n == 0) begin
      chk("deq_data_empty", 192'(deq_data), 192'(0));
    end else begin
      e = sb[0];
      chk("head_inst", 192'(deq_data.inst), 192'(e.inst));
      chk("head_pc", 192'(deq_data.pc), 192'(e.pc));
      chk("head_order", 192'(deq_data.order), 192'(e.order));
    end
    if (!rst_n) begin
      sb.delete();
      m_ord = 64'd0;
    end else if (flush) begin
      sb.delete();
      m_ord = flush_order;
    end else begin
      if (deq_ready && n > 0) void'(sb.pop_front());
      if (enq_valid && n < DEPTH) begin
        sb.push_back('{inst: enq_inst, pc: enq_pc, order: m_ord});
        m_ord = m_ord + 64'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-up reset: DUT state is unknown, so no model checks until it settles.
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ord = 64'd0;
    chk("rst_deq_valid", 192'(deq_valid), 192'(0));
    chk("rst_enq_ready", 192'(enq_ready), 192'(1));
    chk("rst_count", 192'(count), 192'(0));
    chk("rst_deq_data", 192'(deq_data), 192'(0));

    // Single pass
    drive(1'b1, 32'h1eceb000, 1'b0);
    tick();
    chk("sp_pc", 192'(deq_data.pc), 192'(32'h1eceb000));
    chk("sp_inst", 192'(deq_data.inst), 192'(32'h1eceb000 ^ 32'h00500093));
    chk("sp_order", 192'(deq_data.order), 192'(0));
    chk("sp_count", 192'(count), 192'(1));
    drive(1'b0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    tick();

    // Fill to full from a fresh reset, then attempt a 17th enqueue
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 32'h1eceb000 + 32'(4 * k), 1'b0);
      tick();
    end
    chk("full_count", 192'(count), 192'(16));
    chk("full_enq_ready", 192'(enq_ready), 192'(0));
    drive(1'b1, 32'hdead0000, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    for (int k = 0; k < DEPTH; k++) tick();
    drive(1'b0, 32'd0, 1'b0);
    tick();

    // Wrap with continuous simultaneous traffic
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h2000 + 32'(4 * k), 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h3000 + 32'(4 * k), 1'b1);
      tick();
      chk("stream_cnt_le1", 192'(count <= 5'd1), 192'(1));
      chk("stream_order", 192'(deq_data.order), 192'(10 + k));
    end
    drive(1'b0, 32'd0, 1'b1);
    tick();
    tick();

    // Flush dominates same-cycle enqueue and dequeue
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h4000 + 32'(4 * k), 1'b0);
      tick();
    end
    drive(1'b1, 32'h4fff0, 1'b1, 1'b1, 64'h40);
    tick();
    chk("flush_count", 192'(count), 192'(0));
    chk("flush_deq_valid", 192'(deq_valid), 192'(0));
    drive(1'b1, 32'h5000, 1'b0);
    tick();
    chk("flush_order", 192'(deq_data.order), 192'(64'h40));
    drive(1'b0, 32'd0, 1'b1);
    tick();

    // Reset mid-stream with 7 entries held
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 32'h6000 + 32'(4 * k), 1'b0);
      tick();
    end
    chk("mid_count7", 192'(count), 192'(7));
    rst_n = 1'b0;
    drive(1'b1, 32'h6ff0, 1'b1);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_count", 192'(count), 192'(0));
    chk("mid_rst_deq_valid", 192'(deq_valid), 192'(0));
    drive(1'b1, 32'h7000, 1'b0);
    tick();
    chk("mid_rst_order", 192'(deq_data.order), 192'(0));
    drive(1'b0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
